maze_map_memory: RTL and testbench

- Responder side of the mouse map-memory interface: holds the 16x16 maze bitmap that the maze-solving mouse top reads through RD/poseX/poseY and updates through WR/Dout.
- Cell bit 1 = blocked (wall or visited); bit 0 = free.
- Adds a row-serial load port so the testbench or host fills the maze before the mouse is started.
- Sits beside the mouse top. The mouse's Dout drives MapWrData; MapRdData drives the mouse's Din.

---
 rtl/maze_pkg.sv | 17 +
 rtl/maze_map_array.sv | 57 +++++
 rtl/maze_map_memory.sv | 126 ++++++++++++
 tb/tb_maze_map_memory.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the maze map memory: coordinate width, map size, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package maze_pkg;

  localparam int CW    = 4;
  localparam int MAP_N = 1 << CW;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } map_state_t;

endpackage

// File: rtl/maze_map_array.sv
// 2^CW x 2^CW bit storage: one row-wide write port, one bit write port, one registered bit read.
// Latency: writes land on the clock edge; read data is valid one edge after rd_en.
// Backpressure: none; every enabled access is performed in its cycle.
//
// Ports:
//   CLK, RST      clock / async active-low clear of every cell and the read register
//   row_we/sel/dat  full-row write (map load)
//   bit_we/x/y/dat  single-cell write
//   rd_en/x/y       single-cell read request; rd_dat holds until the next rd_en
module maze_map_array
  import maze_pkg::*;
#(
  parameter int CW = maze_pkg::CW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              row_we,
  input  logic [CW-1:0]     row_sel,
  input  logic [(1<<CW)-1:0] row_dat,
  input  logic              bit_we,
  input  logic [CW-1:0]     bit_x,
  input  logic [CW-1:0]     bit_y,
  input  logic              bit_dat,
  input  logic              rd_en,
  input  logic [CW-1:0]     rd_x,
  input  logic [CW-1:0]     rd_y,
  output logic              rd_dat
);

  localparam int N = 1 << CW;

  // mem[y][x]: row-major so a whole row is one packed slice.
  logic [N-1:0][N-1:0] mem;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem <= '0;
    end else begin
      if (row_we) begin
        mem[row_sel] <= row_dat;
      end
      if (bit_we) begin
        mem[bit_y][bit_x] <= bit_dat;
      end
    end
  end

  // Sampling the pre-edge contents gives read-before-write on a same-cell RD+WR.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_dat <= 1'b0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_y][rd_x];
    end
  end

endmodule

// File: rtl/maze_map_memory.sv
// Mouse-facing maze map memory with a row-serial load port and load-sequencing FSM.
// Latency: reads return one edge after RD; LoadDone pulses the cycle after the last row.
// Backpressure: none; Busy flags LOAD, during which RD/WR are ignored.
//
// Ports:
//   CLK, RST                 clock / async active-low reset (clears map, FSM, counters)
//   LoadStart, LoadValid, LoadRow   start (or restart) a load, then one row per valid cycle
//   LoadDone, Busy           load complete pulse / load in progress
//   poseX, poseY, RD, WR, MapWrData, MapRdData   mouse access port
//   ProtErr                  only with MAP_PROTECT_EN: pulses on a suppressed write to
//                            the start cell (0,0) or target cell (max,max)
module maze_map_memory
  import maze_pkg::*;
#(
  parameter int CW = maze_pkg::CW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LoadStart,
  input  logic               LoadValid,
  input  logic [(1<<CW)-1:0] LoadRow,
  output logic               LoadDone,
  output logic               Busy,
  input  logic [CW-1:0]      poseX,
  input  logic [CW-1:0]      poseY,
  input  logic               RD,
  input  logic               WR,
  input  logic               MapWrData,
  output logic               MapRdData
`ifdef MAP_PROTECT_EN
  ,
  output logic               ProtErr
`endif
);

  localparam logic [CW-1:0] CMAX = '1;

  map_state_t    state_q, state_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic          done_d;
  logic          row_we;
  logic          access_ok;
  logic          rd_en;
  logic          wr_hit;
  logic          bit_we;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      LoadDone  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      LoadDone  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    done_d    = 1'b0;
    row_we    = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (LoadStart) begin
          state_d   = LOAD;
          row_cnt_d = '0;
        end
      end
      LOAD: begin
        // A restart takes priority over a row offered in the same cycle.
        if (LoadStart) begin
          row_cnt_d = '0;
        end else if (LoadValid) begin
          row_we    = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;  // wraps to 0 on the last row
          if (row_cnt_q == CMAX) begin
            state_d = READY;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q == LOAD);
  assign access_ok = (state_q != LOAD);
  assign rd_en     = RD & access_ok;
  assign wr_hit    = WR & access_ok;

`ifdef MAP_PROTECT_EN
  logic prot_cell;
  assign prot_cell = ((poseX == '0)   && (poseY == '0)) ||
                     ((poseX == CMAX) && (poseY == CMAX));
  assign bit_we    = wr_hit & ~prot_cell;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ProtErr <= 1'b0;
    end else begin
      ProtErr <= wr_hit & prot_cell;
    end
  end
`else
  assign bit_we = wr_hit;
`endif

  maze_map_array #(.CW(CW)) u_array (
    .CLK     (CLK),
    .RST     (RST),
    .row_we  (row_we),
    .row_sel (row_cnt_q),
    .row_dat (LoadRow),
    .bit_we  (bit_we),
    .bit_x   (poseX),
    .bit_y   (poseY),
    .bit_dat (MapWrData),
    .rd_en   (rd_en),
    .rd_x    (poseX),
    .rd_y    (poseY),
    .rd_dat  (MapRdData)
  );

endmodule

// File: tb/tb_maze_map_memory.sv
// Scoreboard bench for maze_map_memory against a cell-array reference model.
// Latency: the model predicts outputs after every stimulus edge; the monitor checks each cycle.
// Backpressure: n/a.
module tb_maze_map_memory;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LoadStart = 1'b0;
  logic        LoadValid = 1'b0;
  logic [15:0] LoadRow = '0;
  logic        LoadDone;
  logic        Busy;
  logic [3:0]  poseX = '0;
  logic [3:0]  poseY = '0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic        MapWrData = 1'b0;
  logic        MapRdData;
`ifdef MAP_PROTECT_EN
  logic        ProtErr;
`endif

  always #5 CLK = ~CLK;

  maze_map_memory dut (
    .CLK       (CLK),
    .RST       (RST),
    .LoadStart (LoadStart),
    .LoadValid (LoadValid),
    .LoadRow   (LoadRow),
    .LoadDone  (LoadDone),
    .Busy      (Busy),
    .poseX     (poseX),
    .poseY     (poseY),
    .RD        (RD),
    .WR        (WR),
    .MapWrData (MapWrData),
    .MapRdData (MapRdData)
`ifdef MAP_PROTECT_EN
    ,
    .ProtErr   (ProtErr)
`endif
  );

  typedef struct packed {
    logic rd;
    logic done;
    logic busy;
    logic prot;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the map as plain rows plus "are we loading, how many rows so far".
  logic [15:0] m_row [16];
  bit          m_loading = 0;
  int          m_rows = 0;
  logic        m_rd = 1'b0;

  function automatic bit is_prot(input logic [3:0] x, input logic [3:0] y);
`ifdef MAP_PROTECT_EN
    return (x == 4'd0 && y == 4'd0) || (x == 4'd15 && y == 4'd15);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // One stimulus cycle: drive, let the edge happen, advance the model, post expectation.
  task automatic cyc(input logic ls, input logic lv, input logic [15:0] row,
                     input logic [3:0] x, input logic [3:0] y,
                     input logic rd, input logic wr, input logic wd);
    exp_t e;
    bit   done = 0;
    bit   perr = 0;
    @(negedge CLK); #2;
    LoadStart = ls; LoadValid = lv; LoadRow = row;
    poseX = x; poseY = y; RD = rd; WR = wr; MapWrData = wd;
    @(posedge CLK); #1;
    if (m_loading) begin
      if (ls) begin
        m_rows = 0;
      end else if (lv) begin
        m_row[m_rows] = row;
        m_rows++;
        if (m_rows == 16) begin
          m_loading = 0;
          m_rows = 0;
          done = 1;
        end
      end
    end else begin
      if (rd) m_rd = m_row[y][x];
      if (wr) begin
        if (is_prot(x, y)) perr = 1;
        else m_row[y][x] = wd;
      end
      if (ls) begin
        m_loading = 1;
        m_rows = 0;
      end
    end
    e.rd = m_rd; e.done = done; e.busy = m_loading; e.prot = perr;
    exp_q.push_back(e);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 16'h0, 4'd0, 4'd0, 0, 0, 0);
  endtask

  task automatic rd_cell(input int x, input int y);
    cyc(0, 0, 16'h0, 4'(x), 4'(y), 1, 0, 0);
  endtask

  task automatic wr_cell(input int x, input int y, input logic d);
    cyc(0, 0, 16'h0, 4'(x), 4'(y), 0, 1, d);
  endtask

  task automatic read_all();
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        rd_cell(xx, yy);
  endtask

  // Start a load and send nrows random rows with nstall stalls; RD/WR noise rides along.
  task automatic load_rand(input int nrows, input int nstall);
    int sent = 0;
    int stalls = 0;
    cyc(1, 0, 16'h0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    while (sent < nrows) begin
      if (stalls < nstall && ($urandom_range(0, 3) == 0)) begin
        cyc(0, 0, 16'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1'($urandom));
        stalls++;
      end else begin
        cyc(0, 1, 16'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
        sent++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    RST = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) m_row[i] = '0;
    m_loading = 0; m_rows = 0; m_rd = 1'b0;
    check1("reset_MapRdData", MapRdData, 1'b0);
    check1("reset_LoadDone", LoadDone, 1'b0);
    check1("reset_Busy", Busy, 1'b0);
`ifdef MAP_PROTECT_EN
    check1("reset_ProtErr", ProtErr, 1'b0);
`endif
    LoadStart = 0; LoadValid = 0; LoadRow = '0; RD = 0; WR = 0; MapWrData = 0;
    @(negedge CLK); #2;
    RST = 1'b1;
  endtask

  // Monitor: every cycle that the stimulus posted, compare all observable outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1("MapRdData", MapRdData, e.rd);
        check1("LoadDone", LoadDone, e.done);
        check1("Busy", Busy, e.busy);
`ifdef MAP_PROTECT_EN
        check1("ProtErr", ProtErr, e.prot);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) m_row[i] = '0;
    do_reset();

    // Unloaded map reads back as all free.
    rd_cell(5, 5);
    rd_cell(15, 0);

    // Diagonal load.
    cyc(1, 0, 16'h0, 4'd0, 4'd0, 0, 0, 0);
    for (int y = 0; y < 16; y++) begin
      logic [15:0] r;
      r = 16'h0001 << y;
      cyc(0, 1, r, 4'd0, 4'd0, 0, 0, 0);
    end
    idle_cyc();
    idle_cyc();

    rd_cell(3, 3);
    rd_cell(4, 3);
    idle_cyc();
    wr_cell(7, 2, 1'b1);
    rd_cell(7, 2);
    cyc(0, 0, 16'h0, 4'd9, 4'd9, 1, 1, 1'b1);
    idle_cyc();
    rd_cell(9, 9);
    rd_cell(15, 15);
    rd_cell(0, 0);

    // Restart after row 5, including a LoadStart+LoadValid collision, then 3 stalls.
    load_rand(6, 2);
    cyc(1, 1, 16'hFFFF, 4'd1, 4'd1, 1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 7 || i == 11)
        cyc(0, 0, 16'hFFFF, 4'd2, 4'd2, 1, 1, 1);
      cyc(0, 1, 16'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1'($urandom));
    end
    idle_cyc();
    read_all();

    // Reset in the middle of a load wipes everything.
    load_rand(7, 1);
    do_reset();
    read_all();
    rd_cell(3, 3);

`ifdef MAP_PROTECT_EN
    load_rand(16, 0);
    wr_cell(0, 0, 1'b1);
    wr_cell(15, 15, 1'b1);
    wr_cell(0, 0, 1'b0);
    wr_cell(1, 0, 1'b1);
    rd_cell(0, 0);
    rd_cell(15, 15);
    rd_cell(1, 0);
`endif

    // Random mixed traffic, occasional (re)loads.
    load_rand(16, 3);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 16'($urandom),
          4'($urandom), 4'($urandom), 1'($urandom),
          $urandom_range(0, 2) == 0, 1'($urandom));
    end
    for (int i = 0; i < 40; i++) idle_cyc();
    read_all();

    @(negedge CLK);
    @(negedge CLK); #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
